// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, consumer acknowledge and received-byte status of the UART receiver
interface uart_rx_if;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr;
  logic       busy;
  modport master (output RX, clr_rdy, input rx_data, rdy, frm_err, ovr, busy);
  modport slave (input RX, clr_rdy, output rx_data, rdy, frm_err, ovr, busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with mid-bit sampling, start-glitch rejection, framing/overrun flags and rdy/clr_rdy handshake
module uart_rx #(
  parameter int BAUD_DIV = 2604
) (
  input logic      clk,
  input logic      rst_n,
  uart_rx_if.slave bus
);
  localparam int CW = $clog2(BAUD_DIV);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;
  state_t        state_q;
  logic [1:0]    sync_q;
  logic [CW-1:0] baud_q;
  logic [3:0]    bit_q;
  logic [7:0]    shift_q, data_q;
  logic          rdy_q, frm_q, ovr_q, busy_q;
  logic          rx_s, tick;
  assign rx_s = sync_q[1];
  assign tick = baud_q == '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      frm_q   <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], bus.RX};
      if (bus.clr_rdy) begin
        rdy_q <= 1'b0;
        ovr_q <= 1'b0;
        frm_q <= 1'b0;
      end
      if (state_q != IDLE && state_q != WAIT_HI && !tick) baud_q <= baud_q - 1'b1;
      case (state_q)
        IDLE: if (!rx_s) begin
          state_q <= START;
          busy_q  <= 1'b1;
          baud_q  <= CW'(BAUD_DIV / 2 - 1);
        end
        START: if (tick) begin
          if (rx_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= DATA;
            bit_q   <= '0;
            baud_q  <= CW'(BAUD_DIV - 1);
          end
        end
        DATA: if (tick) begin
          shift_q <= {rx_s, shift_q[7:1]};
          bit_q   <= bit_q + 4'd1;
          baud_q  <= CW'(BAUD_DIV - 1);
          if (bit_q == 4'd7) state_q <= STOP;
        end
        // set beats a coincident clr_rdy; ovr only when the old byte was never acknowledged
        STOP: if (tick) begin
          if (rx_s) begin
            data_q  <= shift_q;
            rdy_q   <= 1'b1;
            if (rdy_q && !bus.clr_rdy) ovr_q <= 1'b1;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            frm_q   <= 1'b1;
            state_q <= WAIT_HI;
          end
        end
        WAIT_HI: if (rx_s) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
  assign bus.rx_data = data_q;
  assign bus.rdy     = rdy_q;
  assign bus.frm_err = frm_q;
  assign bus.ovr     = ovr_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table vectors, hand-written corner sequences and random frames against a flag-level reference model
module tb_uart_rx;
  localparam int B = 16;
  localparam int LAT = B / 2 + 9 * B + 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  uart_rx_if bus();
  uart_rx #(.BAUD_DIV(B)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic [7:0] m_data;
  logic m_rdy, m_ovr, m_frm;
  typedef struct {
    logic [7:0] b;
    logic       ok;
    logic       clr;
    logic [7:0] data;
    logic       rdy;
    logic       ovr;
    logic       frm;
  } vec_t;
  vec_t vecs[6];
  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask
  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask
  task automatic m_reset();
    m_data = 8'h00;
    m_rdy = 1'b0;
    m_ovr = 1'b0;
    m_frm = 1'b0;
  endtask
  task automatic m_clr();
    m_rdy = 1'b0;
    m_ovr = 1'b0;
    m_frm = 1'b0;
  endtask
  task automatic m_frame(input logic [7:0] b, input logic ok);
    if (ok) begin
      if (m_rdy) m_ovr = 1'b1;
      m_rdy = 1'b1;
      m_data = b;
    end else m_frm = 1'b1;
  endtask
  task automatic check_all(input string name);
    check8({name, "_data"}, bus.rx_data, m_data);
    check1({name, "_rdy"}, bus.rdy, m_rdy);
    check1({name, "_ovr"}, bus.ovr, m_ovr);
    check1({name, "_frm"}, bus.frm_err, m_frm);
  endtask
  // a bad stop bit leaves the line low for three more bit times (break)
  task automatic send_frame(input logic [7:0] b, input logic ok);
    logic [9:0] f;
    f = {ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.RX = f[i];
      repeat (B) @(negedge clk);
    end
    if (!ok) repeat (3 * B) @(negedge clk);
  endtask
  task automatic finish_bad();
    bus.RX = 1'b1;
    repeat (4) @(negedge clk);
    check1("wait_hi_exit_busy", bus.busy, 1'b0);
  endtask
  task automatic pulse_clr();
    bus.clr_rdy = 1'b1;
    @(negedge clk);
    bus.clr_rdy = 1'b0;
    m_clr();
  endtask
  initial begin
    int lat;
    logic seen;
    bus.RX = 1'b1;
    bus.clr_rdy = 1'b0;
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h47, 1'b1, 1'b0, 8'h47, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h53, 1'b1, 1'b1, 8'h53, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h81, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    check_all("reset");
    check1("reset_busy", bus.busy, 1'b0);
    repeat (50) @(negedge clk);
    check_all("idle");
    check1("idle_busy", bus.busy, 1'b0);
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      while (!bus.rdy && lat < 400) begin
        @(negedge clk);
        lat++;
      end
    join
    m_frame(8'hA5, 1'b1);
    checks++;
    if (lat < LAT - 1 || lat > LAT + 1) begin
      errors++;
      $display("FAIL latency: got %0d clks expected %0d +-1", lat, LAT);
    end
    check_all("valid");
    check1("valid_busy", bus.busy, 1'b0);
    pulse_clr();
    check1("clr_rdy_low", bus.rdy, 1'b0);
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].b, vecs[i].ok);
      m_frame(vecs[i].b, vecs[i].ok);
      check8($sformatf("vec%0d_data", i), bus.rx_data, vecs[i].data);
      check1($sformatf("vec%0d_rdy", i), bus.rdy, vecs[i].rdy);
      check1($sformatf("vec%0d_ovr", i), bus.ovr, vecs[i].ovr);
      check1($sformatf("vec%0d_frm", i), bus.frm_err, vecs[i].frm);
      check1($sformatf("vec%0d_busy", i), bus.busy, !vecs[i].ok);
      if (!vecs[i].ok) finish_bad();
      if (vecs[i].clr) begin
        pulse_clr();
        check1($sformatf("vec%0d_clr_rdy", i), bus.rdy, 1'b0);
        check1($sformatf("vec%0d_clr_ovr", i), bus.ovr, 1'b0);
        check1($sformatf("vec%0d_clr_frm", i), bus.frm_err, 1'b0);
      end
    end
    seen = 1'b0;
    bus.RX = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (i == 5) bus.RX = 1'b1;
      @(negedge clk);
      seen |= bus.busy;
    end
    check1("glitch_busy_pulse", seen, 1'b1);
    check1("glitch_busy_end", bus.busy, 1'b0);
    check_all("glitch");
    send_frame(8'h3C, 1'b1);
    m_frame(8'h3C, 1'b1);
    check_all("after_glitch");
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (88) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check8("midrst_data", bus.rx_data, 8'h00);
        check1("midrst_rdy", bus.rdy, 1'b0);
        check1("midrst_ovr", bus.ovr, 1'b0);
        check1("midrst_frm", bus.frm_err, 1'b0);
        check1("midrst_busy", bus.busy, 1'b0);
        rst_n = 1'b1;
      end
    join
    m_reset();
    check_all("post_reset");
    send_frame(8'h12, 1'b1);
    m_frame(8'h12, 1'b1);
    check_all("after_reset");
    fork
      send_frame(8'h6E, 1'b1);
      begin
        repeat (LAT - 1) @(negedge clk);
        bus.clr_rdy = 1'b1;
        @(negedge clk);
        bus.clr_rdy = 1'b0;
      end
    join
    m_clr();
    m_frame(8'h6E, 1'b1);
    check_all("coincident");
    for (int i = 0; i < 12; i++) begin
      logic [7:0] b;
      logic ok;
      b = 8'($urandom);
      ok = $urandom_range(0, 4) != 0;
      if ($urandom_range(0, 2) == 0) pulse_clr();
      send_frame(b, ok);
      m_frame(b, ok);
      check_all($sformatf("rand%0d", i));
      check1($sformatf("rand%0d_busy", i), bus.busy, !ok);
      if (!ok) finish_bad();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver for BLE command bytes (e.g. 'G' = 0x47, 'S' = 0x53) arriving on the Segway RX pin.
- It is the receive end of the link driven by UART_tx.
- It oversamples with a baud counter, rejects start-bit glitches, and detects framing errors and overrun.
- It presents each byte with a rdy/clr_rdy handshake to the command-processing logic.

Parameters:
- BAUD_DIV, 2604, clk cycles per bit (50 MHz / 19200 baud); must be even and at least 8.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising clk edge.
- RX  input  1  asynchronous serial input; idles high.
- clr_rdy  input  1  consumer acknowledge; clears rdy, ovr and frm_err.
- rx_data  output  8  last correctly framed byte.
- rdy  output  1  a new byte is valid in rx_data.
- frm_err  output  1  sticky flag: stop bit sampled low.
- ovr  output  1  sticky flag: a byte completed while rdy was already 1.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low at a clk edge):
  - Outputs: rx_data=0x00, rdy=0, frm_err=0, ovr=0, busy=0.
  - Internal: both synchronizer flops=1, state=IDLE, counters=0.
  - Reset overrides all other inputs, including in the middle of a byte.
- Synchronizer: RX passes through a 2-flop synchronizer to give rx_s. All decisions use rx_s.
- State IDLE:
  - When rx_s=0: go to START and load baud_cnt so the next sample falls BAUD_DIV/2 clks later (mid start bit).
- State START (sample at mid start bit):
  - rx_s=1: the start was a glitch. Return to IDLE; no flag changes.
  - rx_s=0: set bit_cnt=0 and go to DATA; samples then occur every BAUD_DIV clks.
- State DATA:
  - At each sample, shift rx_s in at the MSB, so the byte is received LSB first. Increment bit_cnt.
  - After the 8th sample, go to STOP.
- State STOP (one sample BAUD_DIV clks after the last data bit):
  - rx_s=1: on the next clk, load rx_data from the shift register and set rdy=1. Return to IDLE.
  - rx_s=0: rx_data is unchanged, rdy is unchanged, frm_err=1. Go to WAIT_HI.
- State WAIT_HI: stay until rx_s=1, then go to IDLE. This stops a break condition from re-triggering a start.
- Latency: rdy rises BAUD_DIV/2 + 9*BAUD_DIV + 1 clks (±1) after rx_s falls, plus 2 synchronizer clks measured from RX. For the default this is 24739 clks ±1 after rx_s falls.
- Overrun:
  - If a byte completes while rdy=1 and clr_rdy=0: ovr=1, rx_data is overwritten with the new byte, rdy stays 1.
- clr_rdy:
  - rdy, ovr and frm_err go to 0 on the clk following clr_rdy=1.
  - clr_rdy does not disturb a reception in progress.
- Simultaneous events:
  - clr_rdy on the same clk that a byte completes: set wins. rdy=1, rx_data=new byte, ovr=0.
  - clr_rdy on the same clk as a stop-bit error: frm_err=1.
- Back-to-back frames: a new start bit arriving immediately after a valid stop sample is detected with no lost bits.
- Counter widths:
  - baud_cnt has clog2(BAUD_DIV) bits and must never wrap in any state.
  - bit_cnt has 4 bits and saturates behaviour at 8.
- Idle line: rx_s stuck high means the block stays in IDLE indefinitely with no output changes.

Test Plan:
- Valid byte: UART_tx (same baud) sends 0xA5 → rdy=1 at 24741±2 clks after trmt, rx_data=0xA5, frm_err=0, ovr=0, busy=0 afterwards. Then pulse clr_rdy → rdy=0 on the next clk.
- Overrun: send 0x47 then 0x53 back-to-back with no clr_rdy → after the second byte rx_data=0x53, rdy=1, ovr=1. Then pulse clr_rdy → rdy=0 and ovr=0.
- Start glitch: drive RX low for 100 clks, then high → busy pulses, state returns to IDLE, rdy stays 0, rx_data is unchanged. A following 0x3C is still received correctly.
- Framing error:
  - Bit-bang 0x81 with the stop bit low, holding RX low for a further 3*BAUD_DIV clks → frm_err=1, rdy=0, rx_data unchanged, busy stays high until RX returns high.
  - Then send 0x55 → rx_data=0x55, rdy=1.
- Reset mid-byte: assert rst_n low for 1 clk during data bit 4 of 0xFF → all outputs 0 on the next clk. Release reset and send 0x12 → rx_data=0x12, rdy=1.
- Coincident clear: assert clr_rdy exactly on the completion clk of byte 0x6E, while rdy=1 from an earlier byte → rdy=1, ovr=0, rx_data=0x6E.
